// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Main control FSM for the multi-cycle RV32I core. Sequences the
//             shared memory port, ALU and PC/IR/ALUOut/Data registers across
//             several cycles per instruction and drives every datapath
//             enable and mux select.
//  Options  : MULTICYCLE_ILLEGAL_TRAP_EN - when defined, an unknown opcode
//             parks the FSM in HALT with the sticky illegal flag raised;
//             otherwise it retires as a 2-cycle NOP.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_ctrl,
  output logic       instr_done,
  output logic       illegal
);

  // State encoding; any code above HALT falls back to FETCH.
  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_HALT     = STATE_W'(11);

  // RV32I major opcodes handled by this core.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // The encoding above needs at least four bits.
  generate
    if (STATE_W < 4) begin : g_state_w_check
      $error("multicycle_ctrl: STATE_W must be >= 4");
    end
  endgenerate

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               op_known;
  logic               br_taken;

  // Shared R/I ALU decode; sub_en is only ever set for R-type.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Opcode legality and branch resolution (only beq/bne can be taken).
  always_comb begin
    op_known = (opcode == OP_LOAD)  || (opcode == OP_STORE) ||
               (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
               (opcode == OP_JAL)   || (opcode == OP_BRANCH);
    br_taken = (funct3[2:1] == 2'b00) && (zero ^ funct3[0]);
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECR;
          OP_ITYPE:  state_d = S_EXECI;
          OP_JAL:    state_d = S_JAL;
          OP_BRANCH: state_d = S_BRANCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:   state_d = S_HALT;
`else
          default:   state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath controls per state; enables are forced low while rst is high.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (opcode)
      OP_STORE:  imm_src = 2'b01;
      OP_BRANCH: imm_src = 2'b10;
      OP_JAL:    imm_src = 2'b11;
      default:   imm_src = 2'b00;
    endcase

    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
        instr_done = !op_known;
`endif
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_decode(funct3, funct7_5);
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_decode(funct3, 1'b0);
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_ctrl   = ALU_SUB;
        pc_write   = br_taken;
        instr_done = 1'b1;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_HALT: begin
        illegal = 1'b1;
      end
`endif
      default: ;
    endcase

    if (rst) begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

`default_nettype wire
